// File: rtl/fifo_gauge_pkg.sv
// rtl/fifo_gauge_pkg.sv - shared types and saturating-sum helper for the gauge collector
package fifo_gauge_pkg;

  parameter int DEFAULT_COUNT_WIDTH = 32;
  localparam int SUM_MAX_WIDTH = 64;

  typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

  typedef enum logic {
    IDLE,
    EMIT
  } collector_state_e;

  // Clamp a widened sum to the largest value representable in `width` bits.
  function automatic logic [SUM_MAX_WIDTH-1:0] sat_sum(
    input logic [SUM_MAX_WIDTH-1:0] sum,
    input int                       width
  );
    logic [SUM_MAX_WIDTH-1:0] limit;
    limit = (SUM_MAX_WIDTH'(1) << width) - SUM_MAX_WIDTH'(1);
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/fifo_gauge_collector_sum.sv
// rtl/fifo_gauge_collector_sum.sv - combinational N-input widened adder saturating to COUNT_WIDTH
module gauge_sum_sat
  import fifo_gauge_pkg::*;
#(
  parameter int N           = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic [N*COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0]   sum
);

  localparam int SUM_WIDTH = COUNT_WIDTH + $clog2(N) + 1;

  logic [SUM_WIDTH-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + SUM_WIDTH'(count[i*COUNT_WIDTH +: COUNT_WIDTH]);
    end
    sum = COUNT_WIDTH'(sat_sum(SUM_MAX_WIDTH'(acc), COUNT_WIDTH));
  end

endmodule

// File: rtl/fifo_gauge_collector.sv
// rtl/fifo_gauge_collector.sv - snapshots gauge maxima, streams them out, tracks peak aggregate occupancy
module fifo_gauge_collector
  import fifo_gauge_pkg::*;
#(
  parameter int N           = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_WIDTH   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N*COUNT_WIDTH-1:0]       count,
  input  logic [N*COUNT_WIDTH-1:0]       maxcount,
  input  logic                           start,
  output logic                           busy,
  output logic [IDX_WIDTH+COUNT_WIDTH-1:0] odat,
  output logic                           ovld,
  input  logic                           ordy,
  output logic                           olast,
  output logic [COUNT_WIDTH-1:0]         total,
  output logic [COUNT_WIDTH-1:0]         maxtotal
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

  logic [COUNT_WIDTH-1:0] sum_sat;

  gauge_sum_sat #(
    .N           (N),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_sum (
    .count (count),
    .sum   (sum_sat)
  );

  // Aggregate path runs regardless of readout state.
  always_ff @(posedge clk) begin
    if (rst) begin
      total    <= '0;
      maxtotal <= '0;
    end else begin
      total <= sum_sat;
      if (total > maxtotal) maxtotal <= total;
    end
  end

  collector_state_e       state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [IDX_WIDTH-1:0]   next_idx;
  logic [COUNT_WIDTH-1:0] snap [N];

  assign next_idx = idx + IDX_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      ovld  <= 1'b0;
      olast <= 1'b0;
      odat  <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ovld <= 1'b0;
          if (start) begin
            for (int i = 0; i < N; i++) snap[i] <= maxcount[i*COUNT_WIDTH +: COUNT_WIDTH];
            idx   <= '0;
            busy  <= 1'b1;
            ovld  <= 1'b1;
            olast <= (N == 1);
            odat  <= {IDX_WIDTH'(0), maxcount[COUNT_WIDTH-1:0]};
            state <= EMIT;
          end
        end
        EMIT: begin
          // ovld is always high in EMIT, so ordy alone marks an accepted word.
          if (ordy) begin
            if (idx == LAST_IDX) begin
              ovld  <= 1'b0;
              busy  <= 1'b0;
              olast <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= next_idx;
              odat  <= {next_idx, snap[next_idx]};
              olast <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_gauge_collector.md
# fifo_gauge_collector

Sequencer that reads out a bank of N FIFO size gauges after a size-gauging simulation run. It samples every gauge's `count` and `maxcount`, tracks the peak of the aggregate buffered element count across all gauges, and on request streams a coherent snapshot of all per-gauge maxima over a ready/valid interface. It sits beside the gauged FIFOs in the gauging testbench/top and feeds the FIFO-depth extraction flow.

## Interface
Parameters:
- `N`, 4, number of gauges attached (≥1).
- `COUNT_WIDTH`, 32, width of every count value.
- `IDX_WIDTH`, `$clog2(N)` but at least 1, width of the gauge index field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `count`  in  N×COUNT_WIDTH  current occupancy of each gauge.
- `maxcount`  in  N×COUNT_WIDTH  peak occupancy of each gauge.
- `start`  in  1  request a readout; sampled only in IDLE.
- `busy`  out  1  readout in progress.
- `odat`  out  IDX_WIDTH+COUNT_WIDTH  `{idx, maxcount_snapshot[idx]}`.
- `ovld`  out  1  `odat` valid.
- `ordy`  in  1  downstream accepts.
- `olast`  out  1  marks word idx = N-1.
- `total`  out  COUNT_WIDTH  registered saturating sum of all `count[i]`.
- `maxtotal`  out  COUNT_WIDTH  peak of `total` since reset.

## Operation
- Aggregate path, independent of the FSM, every cycle outside reset:
  - `total <= sat(Σ count[i])`. The sum is computed at width COUNT_WIDTH+$clog2(N)+1 and clamps to 2^COUNT_WIDTH−1.
  - `if (total > maxtotal) maxtotal <= total`.
- FSM states: IDLE, EMIT.
  - IDLE and `start`=1: copy all N `maxcount` inputs into the snapshot register array, set idx=0, `ovld`=1, `busy`=1, go to EMIT.
  - IDLE and `start`=0: stay; `ovld`=0.
  - EMIT with `ovld && ordy` and idx<N−1: idx+1; `odat` updates to the next snapshot word.
  - EMIT with `ovld && ordy` and idx=N−1: `ovld`=0, `busy`=0, go to IDLE.
  - EMIT with `ordy`=0: `odat`, `olast` and `ovld` are held stable.
- `start` during EMIT is ignored, not queued. Changes to `maxcount` during EMIT do not affect the emitted words; all N words come from the one snapshot.
- `olast` = `ovld && idx==N−1`.
- N=1: a single word with `olast`=1.

## Timing
- Reset values: `busy`=0, `ovld`=0, `olast`=0, `odat`=0, `total`=0, `maxtotal`=0, state IDLE, idx=0, snapshot cleared.
- `rst` during EMIT: the readout is aborted; all outputs take their reset values in the cycle after the reset edge.
- Readout timing:
  - `start` high at edge t (in IDLE) → `busy`=`ovld`=1 with word 0 from edge t onward.
  - With `ordy` held high, N words arrive on N consecutive cycles; `busy` falls at the edge that accepts word N−1.
  - A `start` asserted in that same acceptance cycle is ignored. The earliest new `start` is sampled the cycle after.
- Aggregate timing:
  - `total` lags `count` by 1 cycle.
  - `maxtotal` lags `count` by 2 cycles.
  - Both continue updating during EMIT.

## Structure
- Shared package `fifo_gauge_pkg`:
  - typedef `count_t` (logic [COUNT_WIDTH−1:0], parameterised via package parameter defaulting to 32).
  - FSM state enum `collector_state_e` {IDLE, EMIT}.
  - function `sat_sum` for the clamped reduction.
- Sub-module `gauge_sum_sat`: combinational N-input widened adder with saturation to COUNT_WIDTH. The collector registers its output.

## Test plan
- Reset, then N=4, `maxcount`={5,9,2,7}, `start` pulse, `ordy`=1 → `odat` = {0,5},{1,9},{2,2},{3,7} on 4 consecutive cycles; `olast` only on idx 3; `busy` low afterwards.
- Same readout with `ordy` toggling 1,0,0,1,…:
  - each word is held unchanged while `ordy`=0;
  - no word is lost or duplicated.
- After `start`, change `maxcount[2]` to 100 while in EMIT → the emitted word for idx 2 is still 2. A `start` pulsed mid-readout produces no second sequence.
- Aggregate path with `count`={3,4,0,1} then {10,0,0,0} then {1,1,1,1}:
  - `total` = 8, 10, 4 one cycle after each input;
  - `maxtotal` ends at 10.
- All `count` = 2^32−1 → `total` = `maxtotal` = 0xFFFFFFFF (saturated, no wrap).
- `rst` asserted while idx=2 and `ovld`=1:
  - next cycle `ovld`=`busy`=`total`=`maxtotal`=0;
  - a subsequent `start` restarts cleanly from idx 0.
